// File: rtl/load_store_unit.sv
// Load/store unit: sub-word load extraction, read-modify-write byte/half stores.
// Ports: req_* CPU side, resp_* completion, mem_* word-wide data memory.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, WRITE, RESP
  } state_t;

  state_t state, state_nx;

  logic              sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic        misal;
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [31:0] merged;

  always_comb begin
    misal = (req_size == 2'b11)
          | ((req_size == 2'b01) & req_addr[0])
          | ((req_size == 2'b10) & (|req_addr[1:0]));
  end

  // Lane shift: byte n of the word sits at bits [8n+7:8n].
  always_comb begin
    sh   = {addr_q[1:0], 3'b000};
    lane = mem_rdata >> sh;
    unique case (size_q)
      2'b00:   load_ext = {{24{sgn_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    if (size_q == 2'b00) begin
      mask = 32'h0000_00ff << sh;
      ins  = {24'd0, wdata_q[7:0]} << sh;
    end else begin
      mask = 32'h0000_ffff << sh;
      ins  = {16'd0, wdata_q[15:0]} << sh;
    end
    merged = (mem_rdata & ~mask) | (ins & mask);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (misal)                   state_nx = RESP;
          else if (!req_we)            state_nx = LOAD;
          else if (req_size == 2'b10)  state_nx = WRITE;
          else                         state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = RESP;
      RMW_RD:  state_nx = WRITE;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            sgn_q   <= req_signed;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= misal;
          end
        end
        LOAD:    rdata_q <= load_ext;
        RMW_RD:  wdata_q <= merged;
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid & err_q;
  assign mem_we     = (state == WRITE);
  assign mem_addr   = (state == IDLE) ? '0 : addr_q[ADDR_W+1:2];
  assign mem_wdata  = wdata_q;

endmodule
